// File: rtl/apb_pkg.sv
// rtl/apb_pkg.sv - shared types and constants for the APB master bridge
package apb_pkg;

    localparam int          NUM_SLAVES        = 4;
    localparam int          SLV_IDX_W         = 2;
    localparam logic [31:0] DEFAULT_BASE_ADDR = 32'h1000_0000;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_ACCESS = 2'd2,
        ST_RESP   = 2'd3
    } apb_state_e;

    typedef struct packed {
        logic                 mapped;
        logic [SLV_IDX_W-1:0] idx;
    } apb_decode_t;

endpackage

// File: rtl/apb_addr_decoder.sv
// rtl/apb_addr_decoder.sv - maps a request address onto one of the four peripheral selects
import apb_pkg::*;

module apb_addr_decoder #(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR
) (
    // Only address bits [31:12] take part in the decode.
    input  logic [19:0] addr_hi,
    output apb_decode_t dec
);

    // Window match on the upper half-word; the 16 KB window holds four 4 KB slaves,
    // anything in the upper three quarters of the 64 KB block is unmapped.
    always_comb begin
        dec.mapped = (addr_hi[19:4] == BASE_ADDR[31:16]) && (addr_hi[3:2] == 2'b00);
        dec.idx    = addr_hi[1:0];
    end

endmodule

// File: rtl/apb_master_bridge.sv
// rtl/apb_master_bridge.sv - single-word request to APB3 initiator with four slave selects
import apb_pkg::*;

module apb_master_bridge #(
    parameter logic [31:0] BASE_ADDR = DEFAULT_BASE_ADDR,
    parameter int          TIMEOUT   = 16
) (
    input  logic        PCLK,
    input  logic        PRESET,
    input  logic        req,
    input  logic        we,
    input  logic [31:0] addr,
    input  logic [31:0] wdata,
    output logic [31:0] rdata,
    output logic        ready,
    output logic        err,
    output logic [31:0] PADDR,
    output logic [31:0] PWDATA,
    output logic        PWRITE,
    output logic        PENABLE,
    output logic        PSEL0,
    output logic        PSEL1,
    output logic        PSEL2,
    output logic        PSEL3,
    input  logic [31:0] PRDATA0,
    input  logic [31:0] PRDATA1,
    input  logic [31:0] PRDATA2,
    input  logic [31:0] PRDATA3,
    input  logic        PREADY0,
    input  logic        PREADY1,
    input  logic        PREADY2,
    input  logic        PREADY3
);

    localparam int             CNT_W    = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

    apb_state_e           r_state;
    logic [31:0]          r_paddr;
    logic [31:0]          r_pwdata;
    logic                 r_pwrite;
    logic [SLV_IDX_W-1:0] r_idx;
    logic [CNT_W-1:0]     r_cnt;
    logic [31:0]          r_rdata;
    logic                 r_err;

    apb_decode_t          w_dec;
    logic [31:0]          w_prdata;
    logic                 w_pready;
    logic [NUM_SLAVES-1:0] w_psel;

    apb_addr_decoder #(
        .BASE_ADDR (BASE_ADDR)
    ) u_dec (
        .addr_hi (addr[31:12]),
        .dec     (w_dec)
    );

    // Pick the response of the latched slave; other slaves' PREADY/PRDATA never matter.
    always_comb begin
        case (r_idx)
            2'd0:    begin w_prdata = PRDATA0; w_pready = PREADY0; end
            2'd1:    begin w_prdata = PRDATA1; w_pready = PREADY1; end
            2'd2:    begin w_prdata = PRDATA2; w_pready = PREADY2; end
            default: begin w_prdata = PRDATA3; w_pready = PREADY3; end
        endcase
    end

    // Select lines are decoded from registered state only, so no PREADY-to-output path exists.
    always_comb begin
        w_psel = '0;
        if ((r_state == ST_SETUP) || (r_state == ST_ACCESS)) begin
            w_psel[r_idx] = 1'b1;
        end
    end

    // Transfer sequencer: latch request, run SETUP/ACCESS, bounded wait, one-cycle response.
    always_ff @(posedge PCLK) begin
        if (PRESET) begin
            r_state  <= ST_IDLE;
            r_paddr  <= '0;
            r_pwdata <= '0;
            r_pwrite <= 1'b0;
            r_idx    <= '0;
            r_cnt    <= '0;
            r_rdata  <= '0;
            r_err    <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (req) begin
                        r_paddr  <= addr;
                        r_pwdata <= wdata;
                        r_pwrite <= we;
                        r_idx    <= w_dec.idx;
                        if (w_dec.mapped) begin
                            r_state <= ST_SETUP;
                        end else begin
                            // Unmapped: answer straight away, no select is ever raised.
                            r_err   <= 1'b1;
                            r_rdata <= '0;
                            r_state <= ST_RESP;
                        end
                    end
                end
                ST_SETUP: begin
                    r_cnt   <= '0;
                    r_state <= ST_ACCESS;
                end
                ST_ACCESS: begin
                    // A PREADY on the last allowed cycle is checked first, so it wins over the abort.
                    if (w_pready) begin
                        if (!r_pwrite) begin
                            r_rdata <= w_prdata;
                        end
                        r_err   <= 1'b0;
                        r_state <= ST_RESP;
                    end else if (r_cnt == CNT_LAST) begin
                        r_err   <= 1'b1;
                        r_rdata <= '0;
                        r_state <= ST_RESP;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                ST_RESP: begin
                    r_state <= ST_IDLE;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign PADDR   = r_paddr;
    assign PWDATA  = r_pwdata;
    assign PWRITE  = r_pwrite;
    assign PENABLE = (r_state == ST_ACCESS);
    assign PSEL0   = w_psel[0];
    assign PSEL1   = w_psel[1];
    assign PSEL2   = w_psel[2];
    assign PSEL3   = w_psel[3];
    assign ready   = (r_state == ST_RESP);
    assign rdata   = r_rdata;
    assign err     = r_err;

endmodule

// File: tb/tb_apb_master_bridge.sv
// tb/tb_apb_master_bridge.sv - self-checking bench for apb_master_bridge
module tb_apb_master_bridge;

    localparam int TIMEOUT = 16;

    logic        PCLK   = 1'b0;
    logic        PRESET = 1'b1;
    logic        req    = 1'b0;
    logic        we     = 1'b0;
    logic [31:0] addr   = '0;
    logic [31:0] wdata  = '0;
    logic [31:0] rdata, PADDR, PWDATA;
    logic        ready, err, PWRITE, PENABLE;
    logic [3:0]  psel;
    logic [3:0]  pready;
    logic [31:0] prd [4];
    int          wait_cfg [4];
    int          acc_cnt = 0;
    logic [3:0]  noise = '0;

    int          checks = 0;
    int          failures = 0;
    logic [31:0] model_rdata = '0;

    int          obs_lat, obs_pen, obs_bad;
    int          obs_psel [4];
    logic        obs_err, obs_ready_after;
    logic [31:0] obs_rdata;

    always #5 PCLK = ~PCLK;

    // Slave model: selected slave answers after wait_cfg[n] extra ACCESS cycles; others toggle noise.
    always @(posedge PCLK) acc_cnt <= PENABLE ? acc_cnt + 1 : 0;
    always @(negedge PCLK) noise <= 4'($urandom);

    for (genvar n = 0; n < 4; n++) begin : g_slv
        assign pready[n] = psel[n] ? (PENABLE && (acc_cnt == wait_cfg[n])) : noise[n];
    end

    apb_master_bridge #(
        .BASE_ADDR (32'h1000_0000),
        .TIMEOUT   (TIMEOUT)
    ) dut (
        .PCLK    (PCLK),
        .PRESET  (PRESET),
        .req     (req),
        .we      (we),
        .addr    (addr),
        .wdata   (wdata),
        .rdata   (rdata),
        .ready   (ready),
        .err     (err),
        .PADDR   (PADDR),
        .PWDATA  (PWDATA),
        .PWRITE  (PWRITE),
        .PENABLE (PENABLE),
        .PSEL0   (psel[0]),
        .PSEL1   (psel[1]),
        .PSEL2   (psel[2]),
        .PSEL3   (psel[3]),
        .PRDATA0 (prd[0]),
        .PRDATA1 (prd[1]),
        .PRDATA2 (prd[2]),
        .PRDATA3 (prd[3]),
        .PREADY0 (pready[0]),
        .PREADY1 (pready[1]),
        .PREADY2 (pready[2]),
        .PREADY3 (pready[3])
    );

    // Reference: outcome of one request from the address map and slave wait count alone.
    task automatic model(input logic we_i, input logic [31:0] a, output int lat, output logic e,
                         output logic [31:0] rd, output int tgt, output int acc);
        logic mapped;
        mapped = (a[31:16] == 16'h1000) && (a[15:14] == 2'b00);
        if (!mapped) begin
            lat = 1; e = 1'b1; tgt = -1; acc = 0;
            model_rdata = '0;
        end else begin
            tgt = int'(a[13:12]);
            if (wait_cfg[tgt] + 1 <= TIMEOUT) begin
                acc = wait_cfg[tgt] + 1;
                e = 1'b0;
                if (!we_i) model_rdata = prd[tgt];
            end else begin
                acc = TIMEOUT;
                e = 1'b1;
                model_rdata = '0;
            end
            lat = acc + 2;
        end
        rd = model_rdata;
    endtask

    // Drive one request from IDLE and record what the bus and response did.
    task automatic run_xfer(input logic we_i, input logic [31:0] a, input logic [31:0] d);
        @(negedge PCLK);
        req = 1'b1; we = we_i; addr = a; wdata = d;
        obs_lat = 0; obs_pen = 0; obs_bad = 0;
        obs_err = 1'b0; obs_rdata = 32'hDEAD_BEEF; obs_ready_after = 1'b0;
        for (int n = 0; n < 4; n++) obs_psel[n] = 0;
        for (int k = 1; k <= 100; k++) begin
            @(posedge PCLK); #1;
            for (int n = 0; n < 4; n++) if (psel[n]) obs_psel[n]++;
            if ((psel != 4'b0) && (PADDR !== a || PWDATA !== d || PWRITE !== we_i)) obs_bad++;
            if (PENABLE) obs_pen++;
            if (ready) begin
                obs_lat = k; obs_err = err; obs_rdata = rdata;
                req = 1'b0;
                break;
            end
        end
        req = 1'b0;
        @(posedge PCLK); #1;
        obs_ready_after = ready;
    endtask

    task automatic test_reset();
        PRESET = 1'b1;
        repeat (2) @(posedge PCLK);
        #1;
        checks++; if ({psel, PENABLE, PWRITE, ready, err} !== 8'h00) begin failures++;
            $display("FAIL reset_ctrl got=%b exp=00000000", {psel, PENABLE, PWRITE, ready, err}); end
        checks++; if (PADDR !== 32'h0) begin failures++; $display("FAIL reset_paddr got=%h exp=0", PADDR); end
        checks++; if (PWDATA !== 32'h0) begin failures++; $display("FAIL reset_pwdata got=%h exp=0", PWDATA); end
        checks++; if (rdata !== 32'h0) begin failures++; $display("FAIL reset_rdata got=%h exp=0", rdata); end
        @(negedge PCLK); PRESET = 1'b0;
        model_rdata = '0;
    endtask

    task automatic test_write_wait1();
        int lat, tgt, acc; logic e; logic [31:0] rd;
        for (int n = 0; n < 4; n++) begin wait_cfg[n] = 0; prd[n] = $urandom; end
        wait_cfg[1] = 1;
        run_xfer(1'b1, 32'h1000_1004, 32'h0000_04D2);
        model(1'b1, 32'h1000_1004, lat, e, rd, tgt, acc);
        checks++; if (obs_psel[1] !== 3) begin failures++; $display("FAIL wr_psel1_cycles got=%0d exp=3", obs_psel[1]); end
        checks++; if (obs_psel[0] + obs_psel[2] + obs_psel[3] !== 0) begin failures++;
            $display("FAIL wr_other_psel got=%0d exp=0", obs_psel[0] + obs_psel[2] + obs_psel[3]); end
        checks++; if (obs_bad !== 0) begin failures++; $display("FAIL wr_bus_fields bad_cycles=%0d exp=0", obs_bad); end
        checks++; if (obs_lat !== 4) begin failures++; $display("FAIL wr_latency got=%0d exp=4", obs_lat); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL wr_err got=%b exp=0", obs_err); end
        checks++; if (obs_rdata !== rd) begin failures++; $display("FAIL wr_rdata_kept got=%h exp=%h", obs_rdata, rd); end
    endtask

    task automatic test_read_wait3();
        int lat, tgt, acc; logic e; logic [31:0] rd;
        for (int n = 0; n < 4; n++) begin wait_cfg[n] = 0; prd[n] = $urandom; end
        wait_cfg[2] = 3; prd[2] = 32'h0000_000F;
        run_xfer(1'b0, 32'h1000_2008, $urandom);
        model(1'b0, 32'h1000_2008, lat, e, rd, tgt, acc);
        checks++; if (obs_pen !== 4) begin failures++; $display("FAIL rd_access_cycles got=%0d exp=4", obs_pen); end
        checks++; if (obs_rdata !== 32'h0000_000F) begin failures++; $display("FAIL rd_rdata got=%h exp=0000000f", obs_rdata); end
        checks++; if (obs_err !== 1'b0) begin failures++; $display("FAIL rd_err got=%b exp=0", obs_err); end
        checks++; if (obs_lat !== lat) begin failures++; $display("FAIL rd_latency got=%0d exp=%0d", obs_lat, lat); end
    endtask

    task automatic test_unmapped();
        logic [31:0] cases [2];
        int lat, tgt, acc; logic e; logic [31:0] rd;
        cases[0] = 32'h2000_0000;
        cases[1] = 32'h1000_4000;
        for (int i = 0; i < 2; i++) begin
            run_xfer(1'b0, cases[i], $urandom);
            model(1'b0, cases[i], lat, e, rd, tgt, acc);
            checks++; if (obs_lat !== lat) begin failures++; $display("FAIL unmapped_latency addr=%h got=%0d exp=%0d", cases[i], obs_lat, lat); end
            checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin failures++;
                $display("FAIL unmapped_resp addr=%h err=%b rdata=%h exp err=1 rdata=0", cases[i], obs_err, obs_rdata); end
            checks++; if (obs_psel[0] + obs_psel[1] + obs_psel[2] + obs_psel[3] !== 0) begin failures++;
                $display("FAIL unmapped_psel addr=%h got=%0d exp=0", cases[i], obs_psel[0] + obs_psel[1] + obs_psel[2] + obs_psel[3]); end
        end
    endtask

    task automatic test_timeout();
        int lat, tgt, acc; logic e; logic [31:0] rd;
        for (int n = 0; n < 4; n++) begin wait_cfg[n] = 0; prd[n] = $urandom; end
        wait_cfg[3] = 1000;
        run_xfer(1'b0, 32'h1000_3000, $urandom);
        checks++; if (obs_pen !== TIMEOUT) begin failures++; $display("FAIL to_access_cycles got=%0d exp=%0d", obs_pen, TIMEOUT); end
        checks++; if (obs_lat !== TIMEOUT + 2) begin failures++; $display("FAIL to_latency got=%0d exp=%0d", obs_lat, TIMEOUT + 2); end
        checks++; if (obs_err !== 1'b1 || obs_rdata !== 32'h0) begin failures++;
            $display("FAIL to_resp err=%b rdata=%h exp err=1 rdata=0", obs_err, obs_rdata); end
        model(1'b0, 32'h1000_3000, lat, e, rd, tgt, acc);
        wait_cfg[3] = TIMEOUT - 1; prd[3] = $urandom;
        run_xfer(1'b0, 32'h1000_3000, $urandom);
        model(1'b0, 32'h1000_3000, lat, e, rd, tgt, acc);
        checks++; if (obs_pen !== TIMEOUT) begin failures++; $display("FAIL last_cycle_access got=%0d exp=%0d", obs_pen, TIMEOUT); end
        checks++; if (obs_err !== 1'b0 || obs_rdata !== rd) begin failures++;
            $display("FAIL last_cycle_resp err=%b rdata=%h exp err=0 rdata=%h", obs_err, obs_rdata, rd); end
    endtask

    task automatic test_reset_mid_access();
        int seen_ready;
        int lat, tgt, acc; logic e; logic [31:0] rd;
        for (int n = 0; n < 4; n++) begin wait_cfg[n] = 0; prd[n] = $urandom; end
        wait_cfg[3] = 50;
        @(negedge PCLK);
        req = 1'b1; we = 1'b1; addr = 32'h1000_3ABC; wdata = $urandom;
        repeat (4) @(posedge PCLK);
        #1;
        checks++; if (PENABLE !== 1'b1 || psel !== 4'b1000) begin failures++;
            $display("FAIL mid_in_access penable=%b psel=%b exp 1 1000", PENABLE, psel); end
        @(negedge PCLK); PRESET = 1'b1; req = 1'b0;
        @(posedge PCLK); #1;
        checks++; if ({psel, PENABLE, PWRITE, ready, err} !== 8'h00 || PADDR !== 32'h0 || PWDATA !== 32'h0 || rdata !== 32'h0) begin
            failures++;
            $display("FAIL mid_reset_outputs ctrl=%b paddr=%h pwdata=%h rdata=%h exp all zero",
                     {psel, PENABLE, PWRITE, ready, err}, PADDR, PWDATA, rdata); end
        model_rdata = '0;
        @(negedge PCLK); PRESET = 1'b0;
        seen_ready = 0;
        repeat (4) begin @(posedge PCLK); #1; if (ready) seen_ready++; end
        checks++; if (seen_ready !== 0) begin failures++; $display("FAIL mid_reset_no_ready got=%0d exp=0", seen_ready); end
        wait_cfg[3] = 0;
        run_xfer(1'b0, 32'h1000_3000, $urandom);
        model(1'b0, 32'h1000_3000, lat, e, rd, tgt, acc);
        checks++; if (obs_lat !== lat || obs_err !== e || obs_rdata !== rd) begin failures++;
            $display("FAIL after_reset_xfer lat=%0d err=%b rdata=%h exp lat=%0d err=%b rdata=%h",
                     obs_lat, obs_err, obs_rdata, lat, e, rd); end
    endtask

    task automatic test_back_to_back();
        logic [15:0] ready_v, psel0_v;
        int rd_ok;
        for (int n = 0; n < 4; n++) begin wait_cfg[n] = 0; prd[n] = $urandom; end
        ready_v = '0; psel0_v = '0; rd_ok = 0;
        @(negedge PCLK);
        req = 1'b1; we = 1'b0; addr = 32'h1000_0010; wdata = $urandom;
        for (int k = 1; k <= 9; k++) begin
            @(posedge PCLK); #1;
            ready_v[k] = ready;
            psel0_v[k] = psel[0];
            if (ready && rdata === prd[0] && !err) rd_ok++;
            if (k == 7) req = 1'b0;
        end
        model_rdata = prd[0];
        checks++; if (ready_v !== 16'h0088) begin failures++; $display("FAIL b2b_ready_pattern got=%h exp=0088", ready_v); end
        checks++; if (psel0_v !== 16'h0066) begin failures++; $display("FAIL b2b_psel0_pattern got=%h exp=0066", psel0_v); end
        checks++; if (rd_ok !== 2) begin failures++; $display("FAIL b2b_rdata good_responses=%0d exp=2", rd_ok); end
    endtask

    task automatic test_random();
        int lat, tgt, acc, kind, s, others; logic e, w; logic [31:0] rd, a;
        for (int it = 0; it < 40; it++) begin
            for (int n = 0; n < 4; n++) begin wait_cfg[n] = $urandom_range(0, TIMEOUT + 2); prd[n] = $urandom; end
            kind = $urandom_range(0, 5);
            s = $urandom_range(0, 3);
            w = 1'($urandom);
            if (kind == 0)      a = {16'h1000 ^ 16'($urandom_range(1, 65535)), 16'($urandom)};
            else if (kind == 1) a = {16'h1000, 2'($urandom_range(1, 3)), 14'($urandom)};
            else                a = {16'h1000, 2'b00, 2'(s), 12'($urandom)};
            run_xfer(w, a, $urandom);
            model(w, a, lat, e, rd, tgt, acc);
            others = 0;
            for (int n = 0; n < 4; n++) if (n != tgt) others += obs_psel[n];
            checks++; if (obs_lat !== lat) begin failures++; $display("FAIL rnd_latency it=%0d addr=%h got=%0d exp=%0d", it, a, obs_lat, lat); end
            checks++; if (obs_err !== e) begin failures++; $display("FAIL rnd_err it=%0d addr=%h got=%b exp=%b", it, a, obs_err, e); end
            checks++; if (obs_rdata !== rd) begin failures++; $display("FAIL rnd_rdata it=%0d addr=%h got=%h exp=%h", it, a, obs_rdata, rd); end
            checks++; if (obs_pen !== acc) begin failures++; $display("FAIL rnd_access it=%0d addr=%h got=%0d exp=%0d", it, a, obs_pen, acc); end
            checks++; if (others !== 0 || (tgt >= 0 && obs_psel[tgt] !== acc + 1)) begin failures++;
                $display("FAIL rnd_psel it=%0d addr=%h others=%0d exp=0 (target cycles exp %0d)", it, a, others, acc + 1); end
            checks++; if (obs_bad !== 0) begin failures++; $display("FAIL rnd_bus_fields it=%0d bad_cycles=%0d exp=0", it, obs_bad); end
            checks++; if (obs_ready_after !== 1'b0) begin failures++; $display("FAIL rnd_ready_width it=%0d got=%b exp=0", it, obs_ready_after); end
        end
    endtask

    initial begin
        for (int n = 0; n < 4; n++) begin wait_cfg[n] = 0; prd[n] = '0; end
        test_reset();
        test_write_wait1();
        test_read_wait3();
        test_unmapped();
        test_timeout();
        test_reset_mid_access();
        test_back_to_back();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog simulation time limit reached");
        $fatal(1);
    end

endmodule
